ewrapper_io_rx_deser: RTL and testbench



---
 rtl/ewrapper_rx_pkg.sv | 20 ++
 rtl/ewrapper_rx_lane_shift.sv | 29 ++
 rtl/ewrapper_io_rx_deser.sv | 179 +++++++++++++++++
 tb/tb_ewrapper_io_rx_deser.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ewrapper_rx_pkg.sv
// ewrapper_rx_pkg: shared types and constants for the eLink receive deserializer.
package ewrapper_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEARCH = 3'd1,
        ST_SETTLE = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAIL   = 3'd4
    } rx_state_t;

    // Wide enough for any RATIO up to 16; the top slices what it needs.
    localparam logic [15:0] DEFAULT_FRAME_PATTERN = 16'h00F0;

    // Width of the bit-offset field for a given word size.
    function automatic int offset_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/ewrapper_rx_lane_shift.sv
// ewrapper_rx_lane_shift: per-lane bit history plus slip-offset window select.
module ewrapper_rx_lane_shift
    import ewrapper_rx_pkg::*;
#(
    parameter int RATIO = 8
) (
    input  logic                             clk_in,
    input  logic                             rst_n,
    input  logic                             bit_first,
    input  logic                             bit_second,
    input  logic [offset_width(RATIO)-1:0]   offset,
    output logic [RATIO-1:0]                 word
);

    logic [2*RATIO-1:0] hist;

    // Shift one bit pair in per cycle; the older bit lands above the newer one.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
        end else begin
            hist <= {hist[2*RATIO-3:0], bit_first, bit_second};
        end
    end

    // Window whose newest bit sits offset bits behind the newest captured bit.
    assign word = hist[offset +: RATIO];

endmodule

// File: rtl/ewrapper_io_rx_deser.sv
// ewrapper_io_rx_deser: fast-clock eLink receive deserializer with manual bit
// slip and automatic frame-pattern alignment.
// Optional build macro RX_POLARITY_INVERT_EN: capture ~DATA_ODD as the first
// bit and ~DATA_EVEN as the second (swapped differential pairs).
//
// state  | meaning
// IDLE   | free running, manual slips honoured
// SEARCH | compare frame lane word per valid, slip on mismatch
// SETTLE | drop one word produced across a slip, then search again
// LOCKED | frame pattern seen MATCH_COUNT times in a row
// FAIL   | every offset tried without lock
module ewrapper_io_rx_deser
    import ewrapper_rx_pkg::*;
#(
    parameter int               LANES         = 9,
    parameter int               RATIO         = 8,
    parameter int               FRAME_LANE    = 8,
    parameter logic [RATIO-1:0] FRAME_PATTERN = DEFAULT_FRAME_PATTERN[RATIO-1:0],
    parameter int               MATCH_COUNT   = 4
) (
    input  logic                             CLK_IN,
    input  logic                             RESET_N,
    input  logic [LANES-1:0]                 DATA_EVEN,
    input  logic [LANES-1:0]                 DATA_ODD,
    input  logic                             BITSLIP,
    input  logic                             ALIGN_START,
    output logic [LANES*RATIO-1:0]           DATA_OUT,
    output logic                             DATA_VALID,
    output logic                             ALIGNED,
    output logic                             ALIGN_FAIL,
    output logic [offset_width(RATIO)-1:0]   SLIP_OFFSET
);

    localparam int OFF_W = offset_width(RATIO);
    localparam int HALF  = RATIO / 2;
    localparam int PH_W  = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int MC_W  = 4;
    localparam int TRY_W = $clog2(RATIO + 1);

    logic [LANES-1:0]       cap_first;
    logic [LANES-1:0]       cap_second;
    logic [LANES*RATIO-1:0] window_flat;
    logic [PH_W-1:0]        phase_q;
    logic                   last_phase;
    logic                   bitslip_q;
    logic                   slip_edge;
    logic [RATIO-1:0]       frame_word;
    logic                   frame_hit;

    rx_state_t              state_q, state_d;
    logic [MC_W-1:0]        match_q, match_d;
    logic [TRY_W-1:0]       try_q, try_d;
    logic [OFF_W-1:0]       offset_q, offset_d, offset_inc;

    // Register the IDDR pair, fixing bit order and polarity on the way in.
    always_ff @(posedge CLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            cap_first  <= '0;
            cap_second <= '0;
        end else begin
`ifdef RX_POLARITY_INVERT_EN
            cap_first  <= ~DATA_ODD;
            cap_second <= ~DATA_EVEN;
`else
            cap_first  <= DATA_EVEN;
            cap_second <= DATA_ODD;
`endif
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        ewrapper_rx_lane_shift #(
            .RATIO (RATIO)
        ) u_shift (
            .clk_in     (CLK_IN),
            .rst_n      (RESET_N),
            .bit_first  (cap_first[l]),
            .bit_second (cap_second[l]),
            .offset     (offset_q),
            .word       (window_flat[l*RATIO +: RATIO])
        );
    end

    assign last_phase = (phase_q == PH_W'(HALF - 1));

    // Free-running word phase; never stalls for alignment.
    always_ff @(posedge CLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            phase_q <= '0;
        end else begin
            phase_q <= last_phase ? '0 : phase_q + PH_W'(1);
        end
    end

    // Latch the selected windows once per word and strobe valid.
    always_ff @(posedge CLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            DATA_OUT   <= '0;
            DATA_VALID <= 1'b0;
        end else begin
            DATA_VALID <= last_phase;
            if (last_phase) begin
                DATA_OUT <= window_flat;
            end
        end
    end

    assign slip_edge  = BITSLIP & ~bitslip_q;
    assign frame_word = DATA_OUT[FRAME_LANE*RATIO +: RATIO];
    assign frame_hit  = (frame_word == FRAME_PATTERN);
    assign offset_inc = (offset_q == OFF_W'(RATIO - 1)) ? '0 : offset_q + OFF_W'(1);

    // Alignment state, counters, slip offset and bitslip edge history.
    always_ff @(posedge CLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            match_q   <= '0;
            try_q     <= '0;
            offset_q  <= '0;
            bitslip_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            match_q   <= match_d;
            try_q     <= try_d;
            offset_q  <= offset_d;
            bitslip_q <= BITSLIP;
        end
    end

    // Next-state logic; ALIGN_START overrides everything including a slip edge.
    always_comb begin
        state_d  = state_q;
        match_d  = match_q;
        try_d    = try_q;
        offset_d = offset_q;
        if (ALIGN_START) begin
            state_d = ST_SEARCH;
            match_d = '0;
            try_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (slip_edge) offset_d = offset_inc;
                end
                ST_SEARCH: begin
                    if (DATA_VALID) begin
                        if (frame_hit) begin
                            match_d = match_q + MC_W'(1);
                            if (match_q == MC_W'(MATCH_COUNT - 1)) state_d = ST_LOCKED;
                        end else begin
                            match_d  = '0;
                            offset_d = offset_inc;
                            try_d    = try_q + TRY_W'(1);
                            state_d  = (try_q == TRY_W'(RATIO - 1)) ? ST_FAIL : ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (DATA_VALID) state_d = ST_SEARCH;
                end
                ST_LOCKED: begin
                    if (slip_edge) begin
                        offset_d = offset_inc;
                        state_d  = ST_IDLE;
                    end
                end
                ST_FAIL: begin
                    if (slip_edge) offset_d = offset_inc;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign ALIGNED     = (state_q == ST_LOCKED);
    assign ALIGN_FAIL  = (state_q == ST_FAIL);
    assign SLIP_OFFSET = offset_q;

endmodule

// File: tb/tb_ewrapper_io_rx_deser.sv
// tb_ewrapper_io_rx_deser: random and directed stimulus for the receive
// deserializer, checked against a serial-stream reference model.
module tb_ewrapper_io_rx_deser;

    localparam int LANES = 9;
    localparam int RATIO = 8;
    localparam int HALF  = RATIO / 2;
    localparam int OW    = $clog2(RATIO);
    localparam int W     = LANES * RATIO;

    logic             CLK_IN = 1'b0;
    logic             RESET_N;
    logic [LANES-1:0] DATA_EVEN;
    logic [LANES-1:0] DATA_ODD;
    logic             BITSLIP;
    logic             ALIGN_START;
    logic [W-1:0]     DATA_OUT;
    logic             DATA_VALID;
    logic             ALIGNED;
    logic             ALIGN_FAIL;
    logic [OW-1:0]    SLIP_OFFSET;

    int n_vec    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int m_off    = 0;
    bit chk_data = 1'b1;
    int l0_mode  = 0;
    int f_mode   = 0;
    logic [LANES-1:0] ser_q[$];

    always #5 CLK_IN = ~CLK_IN;

    ewrapper_io_rx_deser #(
        .LANES         (LANES),
        .RATIO         (RATIO),
        .FRAME_LANE    (8),
        .FRAME_PATTERN (8'hF0),
        .MATCH_COUNT   (4)
    ) dut (
        .CLK_IN      (CLK_IN),
        .RESET_N     (RESET_N),
        .DATA_EVEN   (DATA_EVEN),
        .DATA_ODD    (DATA_ODD),
        .BITSLIP     (BITSLIP),
        .ALIGN_START (ALIGN_START),
        .DATA_OUT    (DATA_OUT),
        .DATA_VALID  (DATA_VALID),
        .ALIGNED     (ALIGNED),
        .ALIGN_FAIL  (ALIGN_FAIL),
        .SLIP_OFFSET (SLIP_OFFSET)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit at serial index s such that the word taken at slip offset k equals p.
    function automatic logic pat_bit(input logic [RATIO-1:0] p, input int s, input int k);
        int idx;
        idx = (3*RATIO - 5 - k - (s % RATIO)) % RATIO;
        return p[idx];
    endfunction

    // Expected word on the current valid: RATIO bits ending k bits before
    // the newest bit that has reached the history, earliest bit at MSB.
    function automatic logic [W-1:0] exp_word(input int k);
        logic [W-1:0] w;
        int top;
        w   = '0;
        top = ser_q.size() - 5 - k;
        for (int l = 0; l < LANES; l++)
            for (int j = 0; j < RATIO; j++)
                if (top - j >= 0) w[l*RATIO + j] = ser_q[top - j][l];
        return w;
    endfunction

    task automatic step(input logic bs, input logic as, input bit slip_takes);
        logic [LANES-1:0] f, s;
        f = LANES'($urandom);
        s = LANES'($urandom);
        if (l0_mode == 1) begin
            f[0] = pat_bit(8'hB2, 2*cyc, 0);
            s[0] = pat_bit(8'hB2, 2*cyc + 1, 0);
        end
        if (f_mode == 1) begin
            f[8] = pat_bit(8'hF0, 2*cyc, 3);
            s[8] = pat_bit(8'hF0, 2*cyc + 1, 3);
        end else if (f_mode == 2) begin
            f[8] = 1'b0;
            s[8] = 1'b0;
        end
`ifdef RX_POLARITY_INVERT_EN
        DATA_EVEN = ~s;
        DATA_ODD  = ~f;
`else
        DATA_EVEN = f;
        DATA_ODD  = s;
`endif
        if (l0_mode == 2) begin
            DATA_EVEN[0] = 1'b1;
            DATA_ODD[0]  = 1'b0;
        end
        BITSLIP     = bs;
        ALIGN_START = as;
        @(posedge CLK_IN);
`ifdef RX_POLARITY_INVERT_EN
        ser_q.push_back(~DATA_ODD);
        ser_q.push_back(~DATA_EVEN);
`else
        ser_q.push_back(DATA_EVEN);
        ser_q.push_back(DATA_ODD);
`endif
        cyc++;
        #1;
        check("valid", W'(DATA_VALID), W'(cyc % HALF == 0));
        if ((cyc % HALF == 0) && chk_data) check("data", DATA_OUT, exp_word(m_off));
        if (slip_takes) m_off = (m_off + 1) % RATIO;
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic to_valid();
        do step(1'b0, 1'b0, 1'b0); while (cyc % HALF != 0);
    endtask

    task automatic do_slip(input bit takes);
        step(1'b1, 1'b0, takes);
        step(1'b0, 1'b0, 1'b0);
    endtask

    // Count valid strobes until the wanted status flag rises; -1 on timeout.
    task automatic wait_flag(input bit want_fail, output int nval);
        int k;
        nval = 0;
        for (k = 0; k < 400; k++) begin
            step(1'b0, 1'b0, 1'b0);
            if (DATA_VALID === 1'b1) nval++;
            if ((want_fail ? ALIGN_FAIL : ALIGNED) === 1'b1) break;
        end
        if (k == 400) nval = -1;
    endtask

    initial begin
        int nv;
        RESET_N     = 1'b0;
        BITSLIP     = 1'b0;
        ALIGN_START = 1'b0;
        DATA_EVEN   = '0;
        DATA_ODD    = '0;
        #2;
        check("rst_data",    DATA_OUT, '0);
        check("rst_valid",   W'(DATA_VALID), '0);
        check("rst_aligned", W'(ALIGNED), '0);
        check("rst_fail",    W'(ALIGN_FAIL), '0);
        check("rst_offset",  W'(SLIP_OFFSET), '0);
        @(negedge CLK_IN);
        @(negedge CLK_IN);
        RESET_N = 1'b1;

        run(40);

        l0_mode = 1;
        run(12);
        to_valid();
        check("frame_b2", W'(DATA_OUT[7:0]), W'(8'hB2));

        do_slip(1'b1);
        check("slip_off1", W'(SLIP_OFFSET), W'(1));
        to_valid();
        to_valid();
        check("slip_59", W'(DATA_OUT[7:0]), W'(8'h59));

        l0_mode = 0;
        for (int i = 0; i < 6; i++) begin
            run($urandom_range(1, 7));
            do_slip(1'b1);
        end
        run(20);
        while (m_off != 0) do_slip(1'b1);
        check("off_back0", W'(SLIP_OFFSET), '0);

        f_mode = 1;
        run(16);
        to_valid();
        chk_data = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        wait_flag(1'b0, nv);
        check("lock_valids", W'(nv), W'(10));
        check("lock_offset", W'(SLIP_OFFSET), W'(3));
        check("lock_nofail", W'(ALIGN_FAIL), '0);
        m_off    = 3;
        chk_data = 1'b1;
        run(12);

        to_valid();
        step(1'b1, 1'b1, 1'b0);
        check("prio_offset", W'(SLIP_OFFSET), W'(3));
        check("prio_aligned", W'(ALIGNED), '0);
        step(1'b0, 1'b0, 1'b0);
        wait_flag(1'b0, nv);
        check("relock_valids", W'(nv), W'(4));
        check("relock_offset", W'(SLIP_OFFSET), W'(3));

        do_slip(1'b1);
        check("lslip_aligned", W'(ALIGNED), '0);
        check("lslip_offset", W'(SLIP_OFFSET), W'(4));
        run(8);

        f_mode = 2;
        run(16);
        to_valid();
        chk_data = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        wait_flag(1'b1, nv);
        check("fail_valids", W'(nv), W'(15));
        check("fail_aligned", W'(ALIGNED), '0);
        check("fail_offset", W'(SLIP_OFFSET), W'(4));
        m_off    = 4;
        chk_data = 1'b1;
        run(8);

        do_slip(1'b1);
        check("fslip_offset", W'(SLIP_OFFSET), W'(5));
        check("fslip_fail", W'(ALIGN_FAIL), W'(1));

        to_valid();
        step(1'b0, 1'b1, 1'b0);
        check("restart_fail", W'(ALIGN_FAIL), '0);
        check("restart_offset", W'(SLIP_OFFSET), W'(5));
        chk_data = 1'b0;
        run(6);

        #3;
        RESET_N = 1'b0;
        #1;
        check("mid_rst_data",    DATA_OUT, '0);
        check("mid_rst_valid",   W'(DATA_VALID), '0);
        check("mid_rst_aligned", W'(ALIGNED), '0);
        check("mid_rst_fail",    W'(ALIGN_FAIL), '0);
        check("mid_rst_offset",  W'(SLIP_OFFSET), '0);
        ser_q.delete();
        cyc      = 0;
        m_off    = 0;
        f_mode   = 0;
        chk_data = 1'b1;
        @(negedge CLK_IN);
        @(negedge CLK_IN);
        RESET_N = 1'b1;
        run(20);

        l0_mode = 2;
        run(8);
        to_valid();
        check("pol_aa", W'(DATA_OUT[7:0]), W'(8'hAA));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
